ysyx_22040386_csr_trap: RTL and testbench
=========================================

Name: ysyx_22040386_csr_trap

Overview:
Machine-mode CSR file and trap controller, sitting directly downstream of the memory-access stage at write-back. It consumes the retiring instruction's CSR write, ecall/mret, trap PC and timer-interrupt-taken signals. It holds mstatus, mie, mip, mtvec, mepc, mcause, mcycle and minstret. It returns read data to decode, the current mtvec/mepc to the stage that computes the next PC, and runs the timer-interrupt request/take/redirect handshake with the pipeline controller.

Parameters:
XLEN, 64, data width of all CSRs
RST_MTVEC, 64'h0, reset value of mtvec

Ports:
i_CSR_clk  in  1  clock
i_CSR_rst  in  1  synchronous active-high reset
i_CSR_valid  in  1  an instruction retires this cycle
i_CSR_ecall  in  1  retiring instruction is ecall
i_CSR_mret  in  1  retiring instruction is mret
i_CSR_wen  in  1  CSR write request
i_CSR_waddr  in  12  CSR write address
i_CSR_wdata  in  XLEN  CSR write data
i_CSR_trap_pc  in  XLEN  PC of the retiring or cancelled instruction
i_CSR_mtip  in  1  CLINT timer-pending level
i_CSR_intr_take  in  1  controller cancelled an instruction for the interrupt (pulse)
i_CSR_raddr  in  12  decode-side read address
o_CSR_rdata  out  XLEN  combinational read data
o_CSR_mtvec  out  XLEN  current mtvec
o_CSR_mepc  out  XLEN  current mepc
o_CSR_intr_req  out  1  timer interrupt request to the controller
o_CSR_redirect  out  1  one-cycle fetch redirect after an interrupt is taken
o_CSR_redirect_pc  out  XLEN  redirect target

Behaviour:
- Clocking and reset
  - Single clock domain; all state updates on the rising edge of i_CSR_clk.
  - Reset is synchronous and active-high (i_CSR_rst).
  - On reset: every CSR = 0 except mtvec = RST_MTVEC; FSM = IDLE; o_CSR_intr_req = 0; o_CSR_redirect = 0; o_CSR_redirect_pc = 0.
- CSR map
  - mstatus 0x300: only MIE[3] and MPIE[7] are writable; MPP[12:11] always reads 2'b11; all other bits read 0.
  - mie 0x304: only MTIE[7] is writable.
  - mtvec 0x305: direct mode only; bits [1:0] are forced to 0 on write.
  - mepc 0x341: bits [1:0] are forced to 0 on write.
  - mcause 0x342: full width, read/write.
  - mip 0x344: read-only; MTIP[7] = i_CSR_mtip; writes are ignored.
  - mcycle 0xB00 and minstret 0xB02: full width, read/write.
  - Any unmapped address reads 0; writes to it are ignored.
- Read port
  - Combinational; returns the pre-edge value (no write-through bypass).
  - Decode handles forwarding.
- Counters
  - mcycle increments every cycle.
  - minstret increments when i_CSR_valid=1 and i_CSR_intr_take=0.
  - A same-cycle software write to either counter wins over its increment.
  - Both counters wrap modulo 2^64.
- Per-cycle update priority (highest first)
  1. i_CSR_intr_take: mepc <= trap_pc; mcause <= 64'h8000_0000_0000_0007; MPIE <= MIE; MIE <= 0. Any same-cycle ecall, mret or wen is discarded.
  2. ecall (with valid): mepc <= trap_pc; mcause <= 11; MPIE <= MIE; MIE <= 0.
  3. mret (with valid): MIE <= MPIE; MPIE <= 1.
  4. wen (with valid): the addressed CSR is written.
  - ecall, mret and wen without i_CSR_valid are ignored.
- Interrupt FSM
  - Define pend = MIE & MTIE & i_CSR_mtip.
  - IDLE: if pend, go to REQ.
  - REQ: o_CSR_intr_req = 1.
    - If i_CSR_intr_take, go to TRAP.
    - Else if !pend (MIE/MTIE cleared or mtip dropped), go to IDLE.
    - The request stays high until one of these occurs.
  - TRAP: one cycle with o_CSR_redirect = 1 and o_CSR_redirect_pc = mtvec (post-trap value); then go to IDLE.
  - Because MIE is 0 after a trap, no re-request occurs until mret restores MIE.
  - i_CSR_intr_take outside REQ is a protocol error: assertion only, state unchanged.
- Derived outputs
  - o_CSR_mtvec and o_CSR_mepc are the registered CSR values.
  - The next-PC logic uses o_CSR_mepc for mret and o_CSR_mtvec for ecall.

Decomposition:
- Shared package ysyx_22040386_csr_pkg holds:
  - CSR address constants (ADDR_MSTATUS, ADDR_MIE, ADDR_MTVEC, ADDR_MEPC, ADDR_MCAUSE, ADDR_MIP, ADDR_MCYCLE, ADDR_MINSTRET);
  - bit indices MSTATUS_MIE = 3, MSTATUS_MPIE = 7, MIP_MTIP = 7;
  - cause constants CAUSE_ECALL_M = 11 and CAUSE_MTIMER = 64'h8000_0000_0000_0007;
  - the FSM state enum {IDLE, REQ, TRAP}.
- One sub-module, ysyx_22040386_intr_fsm: inputs pend and take; outputs req, redirect.
- The CSR register file stays in the top module.

Test Plan:
1. Reset, then read 0x300 / 0x305 / 0xB00 → 0x1800 / RST_MTVEC / 0. The following cycle, 0xB00 reads 1.
2. Write mtvec = 0x8000_0103, then ecall with valid and trap_pc = 0x8000_0040 → mtvec reads 0x8000_0100, mepc = 0x8000_0040, mcause = 11, MIE = 0, MPIE = old MIE.
3. Set mstatus = 0x8 and mie = 0x80, raise mtip → intr_req rises one cycle after pend. Take pulse with trap_pc = 0x8000_0200 → next cycle redirect = 1, redirect_pc = mtvec, mcause = 0x8000_0000_0000_0007, intr_req = 0.
4. While in REQ, write mstatus = 0 (no take) → FSM returns to IDLE and intr_req drops.
5. Take pulse in the same cycle as ecall and wen to mcause = 5 → interrupt values win; mcause ≠ 5 and minstret does not increment.
6. mret after scenario 3 → MIE = 1, MPIE = 1. With mtip still high, intr_req reasserts on the next cycle.

Source files
------------

// File: rtl/ysyx_22040386_csr_pkg.sv
// ysyx_22040386_csr_pkg: CSR addresses, bit positions, trap causes and interrupt FSM states.
package ysyx_22040386_csr_pkg;
  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MTIE     = 7;
  localparam int MIP_MTIP     = 7;
  localparam logic [63:0] CAUSE_ECALL_M = 64'd11;
  localparam logic [63:0] CAUSE_MTIMER  = 64'h8000_0000_0000_0007;
  typedef enum logic [1:0] {IDLE, REQ, TRAP} state_t;
endpackage

// File: rtl/ysyx_22040386_csr_trap_intr_fsm.sv
// ysyx_22040386_intr_fsm: timer-interrupt request/take/redirect handshake.
module ysyx_22040386_intr_fsm
  import ysyx_22040386_csr_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic pend,
  input  logic take,
  output logic req,
  output logic redirect
);
  state_t state;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      req <= 1'b0;
      redirect <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pend) begin
          state <= REQ;
          req <= 1'b1;
        end
        REQ: if (take) begin
          state <= TRAP;
          req <= 1'b0;
          redirect <= 1'b1;
        end else if (!pend) begin
          state <= IDLE;
          req <= 1'b0;
        end
        default: begin
          state <= IDLE;
          redirect <= 1'b0;
        end
      endcase
    end
  end
  // The controller may only cancel an instruction while a request is outstanding.
  assert property (@(posedge clk) disable iff (rst) take |-> state == REQ);
endmodule

// File: rtl/ysyx_22040386_csr_trap.sv
// ysyx_22040386_csr_trap: machine-mode CSR file with ecall/mret/timer-interrupt trap control.
module ysyx_22040386_csr_trap
  import ysyx_22040386_csr_pkg::*;
#(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] RST_MTVEC = '0
) (
  input  logic            i_CSR_clk,
  input  logic            i_CSR_rst,
  input  logic            i_CSR_valid,
  input  logic            i_CSR_ecall,
  input  logic            i_CSR_mret,
  input  logic            i_CSR_wen,
  input  logic [11:0]     i_CSR_waddr,
  input  logic [XLEN-1:0] i_CSR_wdata,
  input  logic [XLEN-1:0] i_CSR_trap_pc,
  input  logic            i_CSR_mtip,
  input  logic            i_CSR_intr_take,
  input  logic [11:0]     i_CSR_raddr,
  output logic [XLEN-1:0] o_CSR_rdata,
  output logic [XLEN-1:0] o_CSR_mtvec,
  output logic [XLEN-1:0] o_CSR_mepc,
  output logic            o_CSR_intr_req,
  output logic            o_CSR_redirect,
  output logic [XLEN-1:0] o_CSR_redirect_pc
);
  logic m_ie, m_pie, m_tie;
  logic [XLEN-1:0] mtvec, mepc, mcause, mcycle, minstret, mstatus, mip;
  logic ec, mr, wr;
  // Exclusive priority: take > ecall > mret > write.
  assign ec = i_CSR_valid & i_CSR_ecall & ~i_CSR_intr_take;
  assign mr = i_CSR_valid & i_CSR_mret & ~i_CSR_intr_take & ~i_CSR_ecall;
  assign wr = i_CSR_valid & i_CSR_wen & ~i_CSR_intr_take & ~i_CSR_ecall & ~i_CSR_mret;
  assign mstatus = XLEN'({2'b11, 3'b0, m_pie, 3'b0, m_ie, 3'b0});
  assign mip = XLEN'({i_CSR_mtip, 7'b0});
  always_comb begin
    case (i_CSR_raddr)
      ADDR_MSTATUS:  o_CSR_rdata = mstatus;
      ADDR_MIE:      o_CSR_rdata = XLEN'({m_tie, 7'b0});
      ADDR_MTVEC:    o_CSR_rdata = mtvec;
      ADDR_MEPC:     o_CSR_rdata = mepc;
      ADDR_MCAUSE:   o_CSR_rdata = mcause;
      ADDR_MIP:      o_CSR_rdata = mip;
      ADDR_MCYCLE:   o_CSR_rdata = mcycle;
      ADDR_MINSTRET: o_CSR_rdata = minstret;
      default:       o_CSR_rdata = '0;
    endcase
  end
  always_ff @(posedge i_CSR_clk) begin
    if (i_CSR_rst) begin
      {m_ie, m_pie, m_tie} <= '0;
      mtvec <= RST_MTVEC;
      {mepc, mcause, mcycle, minstret} <= '0;
    end else begin
      mcycle <= (wr && i_CSR_waddr == ADDR_MCYCLE) ? i_CSR_wdata : mcycle + 1'b1;
      minstret <= (wr && i_CSR_waddr == ADDR_MINSTRET) ? i_CSR_wdata
                : minstret + XLEN'(i_CSR_valid & ~i_CSR_intr_take);
      if (i_CSR_intr_take || ec) begin
        mepc <= i_CSR_trap_pc;
        mcause <= i_CSR_intr_take ? XLEN'(CAUSE_MTIMER) : XLEN'(CAUSE_ECALL_M);
        m_pie <= m_ie;
        m_ie <= 1'b0;
      end else if (mr) begin
        m_ie <= m_pie;
        m_pie <= 1'b1;
      end else if (wr) begin
        case (i_CSR_waddr)
          ADDR_MSTATUS: begin
            m_ie <= i_CSR_wdata[MSTATUS_MIE];
            m_pie <= i_CSR_wdata[MSTATUS_MPIE];
          end
          ADDR_MIE:    m_tie <= i_CSR_wdata[MIE_MTIE];
          ADDR_MTVEC:  mtvec <= {i_CSR_wdata[XLEN-1:2], 2'b00};
          ADDR_MEPC:   mepc <= {i_CSR_wdata[XLEN-1:2], 2'b00};
          ADDR_MCAUSE: mcause <= i_CSR_wdata;
          default: ;
        endcase
      end
    end
  end
  ysyx_22040386_intr_fsm u_fsm (
    .clk(i_CSR_clk),
    .rst(i_CSR_rst),
    .pend(m_ie & m_tie & i_CSR_mtip),
    .take(i_CSR_intr_take),
    .req(o_CSR_intr_req),
    .redirect(o_CSR_redirect)
  );
  assign o_CSR_mtvec = mtvec;
  assign o_CSR_mepc = mepc;
  assign o_CSR_redirect_pc = o_CSR_redirect ? mtvec : '0;
endmodule

// File: tb/tb_ysyx_22040386_csr_trap.sv
// tb_ysyx_22040386_csr_trap: directed scenarios plus random traffic against a behavioural CSR/trap model.
module tb_ysyx_22040386_csr_trap;
  logic clk = 0, rst = 1, valid = 0, ecall = 0, mret = 0, wen = 0, mtip = 0, take = 0;
  logic [11:0] waddr = 0, raddr = 0;
  logic [63:0] wdata = 0, trap_pc = 0;
  logic [63:0] rdata, o_mtvec, o_mepc, rpc;
  logic req, redir;
  int vectors = 0, miss = 0;
  // reference model state
  bit ie, pie, tie, req_m, redir_m;
  logic [63:0] tvec, epc, cause, cyc_m, inst_m;
  logic [11:0] addrs [10] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342,
                             12'h344, 12'hB00, 12'hB02, 12'h123, 12'hF14};

  ysyx_22040386_csr_trap dut (
    .i_CSR_clk(clk), .i_CSR_rst(rst), .i_CSR_valid(valid), .i_CSR_ecall(ecall),
    .i_CSR_mret(mret), .i_CSR_wen(wen), .i_CSR_waddr(waddr), .i_CSR_wdata(wdata),
    .i_CSR_trap_pc(trap_pc), .i_CSR_mtip(mtip), .i_CSR_intr_take(take),
    .i_CSR_raddr(raddr), .o_CSR_rdata(rdata), .o_CSR_mtvec(o_mtvec), .o_CSR_mepc(o_mepc),
    .o_CSR_intr_req(req), .o_CSR_redirect(redir), .o_CSR_redirect_pc(rpc)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rd(input logic [11:0] a);
    case (a)
      12'h300: return 64'h1800 | (64'(ie) << 3) | (64'(pie) << 7);
      12'h304: return 64'(tie) << 7;
      12'h305: return tvec;
      12'h341: return epc;
      12'h342: return cause;
      12'h344: return 64'(mtip) << 7;
      12'hB00: return cyc_m;
      12'hB02: return inst_m;
      default: return 64'h0;
    endcase
  endfunction

  task automatic model_step();
    bit pend, nreq, nred;
    pend = ie & tie & mtip;
    nreq = req_m;
    nred = 0;
    if (redir_m) nreq = 0;
    else if (req_m) begin
      if (take) begin nreq = 0; nred = 1; end
      else if (!pend) nreq = 0;
    end else if (pend) nreq = 1;
    cyc_m += 1;
    if (valid && !take) inst_m += 1;
    if (take || (valid && ecall)) begin
      epc = trap_pc;
      cause = take ? 64'h8000_0000_0000_0007 : 64'd11;
      pie = ie;
      ie = 0;
    end else if (valid && mret) begin
      ie = pie;
      pie = 1;
    end else if (valid && wen) begin
      case (waddr)
        12'h300: begin ie = wdata[3]; pie = wdata[7]; end
        12'h304: tie = wdata[7];
        12'h305: tvec = wdata & ~64'h3;
        12'h341: epc = wdata & ~64'h3;
        12'h342: cause = wdata;
        12'hB00: cyc_m = wdata;
        12'hB02: inst_m = wdata;
        default: ;
      endcase
    end
    req_m = nreq;
    redir_m = nred;
  endtask

  // One clock: check everything against the model, advance model and DUT, clear pulses.
  task automatic tick(input logic [11:0] ra);
    raddr = ra;
    #1;
    chk("rdata", rdata, rd(ra));
    chk("mtvec", o_mtvec, tvec);
    chk("mepc", o_mepc, epc);
    chk("intr_req", 64'(req), 64'(req_m));
    chk("redirect", 64'(redir), 64'(redir_m));
    chk("redirect_pc", rpc, redir_m ? tvec : 64'h0);
    model_step();
    @(posedge clk);
    #1;
    {valid, ecall, mret, wen, take} = '0;
  endtask

  task automatic peek(input logic [11:0] a, input logic [63:0] exp, input string tag);
    raddr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  initial begin
    {ie, pie, tie, req_m, redir_m} = '0;
    {tvec, epc, cause, cyc_m, inst_m} = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    // reset state
    peek(12'h300, 64'h1800, "rst_mstatus");
    peek(12'h305, 64'h0, "rst_mtvec");
    peek(12'hB00, 64'h0, "rst_mcycle");
    chk("rst_redirect_pc", rpc, 64'h0);
    tick(12'hB00);
    peek(12'hB00, 64'h1, "mcycle_inc");
    // mtvec alignment and ecall
    valid = 1; wen = 1; waddr = 12'h305; wdata = 64'h8000_0103; tick(12'h305);
    valid = 1; ecall = 1; trap_pc = 64'h8000_0040; tick(12'h341);
    chk("mtvec_align", o_mtvec, 64'h8000_0100);
    chk("ecall_mepc", o_mepc, 64'h8000_0040);
    peek(12'h342, 64'd11, "ecall_cause");
    // timer interrupt request and take
    valid = 1; wen = 1; waddr = 12'h300; wdata = 64'h8; tick(12'h300);
    valid = 1; wen = 1; waddr = 12'h304; wdata = 64'h80; tick(12'h304);
    chk("req_before_pend", 64'(req), 64'h0);
    mtip = 1; tick(12'h344);
    chk("req_rise", 64'(req), 64'h1);
    tick(12'h0);
    take = 1; valid = 1; trap_pc = 64'h8000_0200; tick(12'h342);
    chk("take_redirect", 64'(redir), 64'h1);
    chk("take_redirect_pc", rpc, 64'h8000_0100);
    chk("take_req_low", 64'(req), 64'h0);
    peek(12'h342, 64'h8000_0000_0000_0007, "take_cause");
    tick(12'h300);
    // mret restores MIE, request reasserts
    valid = 1; mret = 1; tick(12'h300);
    peek(12'h300, 64'h1888, "mret_mstatus");
    tick(12'h0);
    chk("req_reassert", 64'(req), 64'h1);
    // clear MIE while requesting
    valid = 1; wen = 1; waddr = 12'h300; wdata = 64'h0; tick(12'h300);
    tick(12'h0);
    chk("req_drop", 64'(req), 64'h0);
    // take beats same-cycle ecall and mcause write
    valid = 1; wen = 1; waddr = 12'h300; wdata = 64'h8; tick(12'h300);
    tick(12'h0);
    take = 1; valid = 1; ecall = 1; wen = 1; waddr = 12'h342; wdata = 64'h5;
    trap_pc = 64'h8000_0300; tick(12'hB02);
    peek(12'h342, 64'h8000_0000_0000_0007, "take_wins");
    tick(12'hB02);
    // counter wrap
    valid = 1; wen = 1; waddr = 12'hB00; wdata = '1; tick(12'hB00);
    peek(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF, "mcycle_write");
    tick(12'h0);
    peek(12'hB00, 64'h0, "mcycle_wrap");
    // random traffic
    for (int i = 0; i < 400; i++) begin
      valid = 1'($urandom);
      ecall = ($urandom % 8) == 0;
      mret = ($urandom % 6) == 0;
      wen = 1'($urandom);
      waddr = addrs[$urandom % 10];
      wdata = {$urandom, $urandom};
      if ($urandom % 2 == 0) wdata[3] = 1'b1;
      trap_pc = {$urandom, $urandom};
      mtip = ($urandom % 4) != 0;
      take = req_m && ($urandom % 3 == 0);
      tick(addrs[$urandom % 10]);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
